rfid_reader_axil_regs: RTL and testbench
========================================

// Module: rfid_reader_axil_regs
// PURPOSE
//  AXI4-Lite slave register bank for the RFID reader IP; it is the responder the AXI VIP master drives.
//  Assembles 4-byte tag IDs from the reader byte stream, latches them into TAG, and flags NEW/OVERRUN/FRAME_ERR in STATUS.
//  Also holds CTRL and SCRATCH registers. Sits between the PS AXI interconnect and the RFID byte receiver.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32    data width; only 32 is supported
//  C_S_AXI_ADDR_WIDTH  4     byte address width; 4 word registers
//  TIMEOUT_CYCLES      1000  max clocks between tag bytes before the frame is aborted (>=2)
// PORTS
//  S_AXI_ACLK     in   1   single clock
//  S_AXI_ARESETN  in   1   async assert, active-low reset
//  S_AXI_AWADDR   in   4   write address
//  S_AXI_AWPROT   in   3   ignored
//  S_AXI_AWVALID  in   1   / S_AXI_AWREADY out 1
//  S_AXI_WDATA    in   32  write data
//  S_AXI_WSTRB    in   4   byte enables
//  S_AXI_WVALID   in   1   / S_AXI_WREADY out 1
//  S_AXI_BRESP    out  2   always 2'b00 (OKAY)
//  S_AXI_BVALID   out  1   / S_AXI_BREADY in 1
//  S_AXI_ARADDR   in   4   read address
//  S_AXI_ARPROT   in   3   ignored
//  S_AXI_ARVALID  in   1   / S_AXI_ARREADY out 1
//  S_AXI_RDATA    out  32  read data
//  S_AXI_RRESP    out  2   always 2'b00
//  S_AXI_RVALID   out  1   / S_AXI_RREADY in 1
//  tag_byte       in   8   byte from RFID receiver
//  tag_byte_vld   in   1   1-cycle strobe, tag_byte valid
//  irq            out  1   present only with RFID_REGS_IRQ_EN
// BEHAVIOUR
//  Reset: all READY/VALID outputs 0; RDATA 0; all registers 0; byte_cnt 0; irq 0.
//  Register map (ADDR[3:2]): 0 CTRL rw, 1 SCRATCH rw, 2 STATUS ro/W1C, 3 TAG ro.
//   CTRL[0] rx_en; CTRL[1] flush (self-clearing, reads 0); CTRL[2] irq_en; other bits rw, no effect.
//   STATUS[0] new_tag, [1] overrun, [2] frame_err (all W1C); [5:4] byte_cnt (ro); others read 0.
//  Write channel:
//   - AW and W are captured independently, in any order.
//   - AWREADY is 1 while no address is held; WREADY is 1 while no data is held.
//   - The cycle after both are held and BVALID=0: apply the write with WSTRB per byte lane, set BVALID,
//     release both holders.
//   - BVALID holds until BREADY; no new write is applied while BVALID=1.
//   - Writes to TAG are ignored but still receive an OKAY response.
//  Read channel:
//   - ARREADY = !RVALID.
//   - On AR handshake, RDATA is registered and RVALID=1 the next cycle; RDATA/RVALID stay stable until RREADY.
//   - Reads have no side effects.
//  Tag assembly (only when rx_en=1; when rx_en=0, strobes are dropped):
//   - Each strobe shifts tag_byte in MSB-first: shreg <= {shreg[23:0], tag_byte}; byte_cnt++.
//   - On the 4th byte: TAG <= assembled word; byte_cnt=0; new_tag=1.
//     If new_tag was already 1, overrun=1 and TAG is still overwritten.
//   - Gap timer counts clocks while byte_cnt!=0. On reaching TIMEOUT_CYCLES: byte_cnt=0, frame_err=1, timer=0.
//     Each strobe resets the timer.
//   - flush, or a 1->0 transition of rx_en, resets byte_cnt and the timer. Flags and TAG are unaffected.
//  Simultaneous events:
//   - W1C and a hardware set of the same STATUS bit in one cycle: set wins.
//   - Strobe and flush in one cycle: flush wins; the byte is dropped.
//  Reset mid-transfer: all handshakes are abandoned; outputs return to their reset values immediately (async).
// CONFIGURATION
//  RFID_REGS_IRQ_EN defined:
//   - irq port exists; irq is registered: irq <= irq_en & (new_tag|overrun|frame_err), 1-cycle latency.
//  RFID_REGS_IRQ_EN undefined:
//   - No irq port; CTRL[2] is a plain rw bit with no effect.
// TESTING
//  1. Write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read back.
//     -> CTRL=1 (flush bit reads 0), SCRATCH=2, STATUS=0 (W1C of 3 on zero flags), TAG=0; all BRESP/RRESP=0.
//  2. Write 0xDEADBEEF to SCRATCH with WSTRB=4'b0101 after SCRATCH=0.
//     -> readback 0x00AD00EF. Also repeat with W presented 3 cycles before AW -> one B response.
//  3. CTRL=1; bytes 0x12,0x34,0x56,0x78. -> TAG=0x12345678, STATUS=0x1.
//     Then another 4 bytes without clearing -> STATUS=0x3, TAG = new value.
//  4. CTRL=1; 2 bytes, then idle TIMEOUT_CYCLES. -> STATUS[2]=1, byte_cnt=0.
//     Write 0x4 to STATUS -> frame_err=0.
//  5. Hold RREADY=0 for 5 cycles after AR. -> RVALID and RDATA stable, ARREADY=0 throughout.
//     Hold BREADY=0 -> no second write is applied.
//  6. With RFID_REGS_IRQ_EN: CTRL=5, complete a tag -> irq=1 one cycle after new_tag.
//     W1C of 0x1 -> irq=0. Deassert ARESETN mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/rfid_reader_axil_regs_if.sv
// AXI4-Lite bus bundle for the RFID reader register bank.
// The master modport is the PS-side driver and the slave modport is the register bank.
interface rfid_reader_axil_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/rfid_reader_axil_regs.sv
// AXI4-Lite register bank for the RFID reader: CTRL, SCRATCH, STATUS (W1C flags) and TAG.
// Define RFID_REGS_IRQ_EN to add the registered irq output gated by CTRL[2].
module rfid_reader_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES     = 1000
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    rfid_reader_axil_regs_if.slave        s_axi,
    input  logic [7:0]                    tag_byte,
    input  logic                          tag_byte_vld
`ifdef RFID_REGS_IRQ_EN
    ,
    output logic                          irq
`endif
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_SCRATCH = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_TAG     = 2'd3;

    localparam logic [DW-1:0] FLUSH_MASK = 'h2;

    logic          bus_en;
    logic          aw_held;
    logic [1:0]    aw_sel;
    logic          w_held;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;
    logic          bvalid_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

    logic [DW-1:0] ctrl_q;
    logic [DW-1:0] scratch_q;
    logic [DW-1:0] tag_q;
    logic          new_tag;
    logic          overrun;
    logic          frame_err;
    logic [1:0]    byte_cnt;
    logic [23:0]   shreg;
    logic [TW-1:0] timer;

    logic          do_write;
    logic          ctrl_wr;
    logic [DW-1:0] ctrl_next;
    logic          flush;
    logic          rx_stop;
    logic          abort;
    logic          strobe;
    logic          frame_done;
    logic          timeout;
    logic [2:0]    status_clr;
    logic [DW-1:0] status_word;
    logic [DW-1:0] rd_mux;

    wire unused_bus = &{1'b0, s_axi.awprot, s_axi.arprot,
                        s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_val,
                                                  input logic [DW-1:0] new_val,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_val;
        for (int i = 0; i < SW; i++)
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        return res;
    endfunction

    // READY outputs are gated by bus_en so they stay low throughout reset.
    assign s_axi.awready = bus_en & ~aw_held;
    assign s_axi.wready  = bus_en & ~w_held;
    assign s_axi.arready = bus_en & ~rvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;

    assign do_write   = aw_held & w_held & ~bvalid_q;
    assign ctrl_wr    = do_write & (aw_sel == REG_CTRL);
    assign ctrl_next  = merge_lanes(ctrl_q, w_data, w_strb);
    assign flush      = ctrl_wr & ctrl_next[1];
    assign rx_stop    = ctrl_wr & ctrl_q[0] & ~ctrl_next[0];
    assign abort      = flush | rx_stop;
    assign strobe     = tag_byte_vld & ctrl_q[0] & ~abort;
    assign frame_done = strobe & (byte_cnt == 2'd3);
    assign timeout    = ~abort & ~strobe & (byte_cnt != 2'd0) &
                        (timer == TW'(TIMEOUT_CYCLES - 1));
    assign status_clr = {3{do_write & (aw_sel == REG_STATUS) & w_strb[0]}} & w_data[2:0];

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        status_word      = '0;
        status_word[5:4] = byte_cnt;
        status_word[2:0] = {frame_err, overrun, new_tag};
    end

    always_comb begin
        rd_mux = '0;
        case (s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2])
            REG_CTRL:    rd_mux = ctrl_q;
            REG_SCRATCH: rd_mux = scratch_q;
            REG_STATUS:  rd_mux = status_word;
            REG_TAG:     rd_mux = tag_q;
            default:     rd_mux = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            bus_en   <= 1'b0;
            aw_held  <= 1'b0;
            aw_sel   <= '0;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            bus_en <= 1'b1;
            if (s_axi.awvalid && s_axi.awready) begin
                aw_held <= 1'b1;
                aw_sel  <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (s_axi.wvalid && s_axi.wready) begin
                w_held <= 1'b1;
                w_data <= s_axi.wdata;
                w_strb <= s_axi.wstrb;
            end
            if (do_write) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
            end else if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
            if (s_axi.arvalid && s_axi.arready) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Software-visible registers; hardware flag sets take priority over W1C.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_q    <= '0;
            scratch_q <= '0;
            tag_q     <= '0;
            new_tag   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ctrl_wr)
                ctrl_q <= ctrl_next & ~FLUSH_MASK;
            if (do_write && aw_sel == REG_SCRATCH)
                scratch_q <= merge_lanes(scratch_q, w_data, w_strb);
            if (frame_done)
                tag_q <= DW'({shreg, tag_byte});
            new_tag   <= (new_tag   & ~status_clr[0]) | frame_done;
            overrun   <= (overrun   & ~status_clr[1]) | (frame_done & new_tag);
            frame_err <= (frame_err & ~status_clr[2]) | timeout;
        end
    end

    // Byte assembler and inter-byte gap timer.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            shreg    <= '0;
            byte_cnt <= '0;
            timer    <= '0;
        end else if (abort) begin
            byte_cnt <= '0;
            timer    <= '0;
        end else if (strobe) begin
            shreg    <= {shreg[15:0], tag_byte};
            byte_cnt <= byte_cnt + 2'd1;
            timer    <= '0;
        end else if (timeout) begin
            byte_cnt <= '0;
            timer    <= '0;
        end else if (byte_cnt != 2'd0) begin
            timer <= timer + TW'(1);
        end else begin
            timer <= '0;
        end
    end

`ifdef RFID_REGS_IRQ_EN
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)
            irq <= 1'b0;
        else
            irq <= ctrl_q[2] & (new_tag | overrun | frame_err);
    end
`endif

endmodule

// File: tb/tb_rfid_reader_axil_regs.sv
// Directed bench for rfid_reader_axil_regs: register table, handshake stalls, tag assembly,
// gap timeout, flush/rx_en handling, optional irq and asynchronous reset mid-transfer.
module tb_rfid_reader_axil_regs;

    localparam int TMO = 40;

    logic       clk;
    logic       rst_n;
    logic [7:0] tag_byte;
    logic       tag_byte_vld;
`ifdef RFID_REGS_IRQ_EN
    logic       irq;
`endif

    int total = 0;
    int bad   = 0;

    rfid_reader_axil_regs_if #(.ADDR_W(4), .DATA_W(32)) axi ();

    rfid_reader_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .s_axi(axi),
        .tag_byte(tag_byte),
        .tag_byte_vld(tag_byte_vld)
`ifdef RFID_REGS_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit          is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no handshake expected one within the cycle budget", name);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic aw_only(input logic [3:0] addr);
        logic hs;
        bit   done;
        axi.awaddr  = addr;
        axi.awvalid = 1'b1;
        done = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            hs = axi.awready;
            @(posedge clk);
            #1;
            if (hs) done = 1;
        end
        axi.awvalid = 1'b0;
        if (!done) fail_timeout("aw_handshake");
    endtask

    task automatic w_only(input logic [31:0] data, input logic [3:0] strb);
        logic hs;
        bit   done;
        axi.wdata  = data;
        axi.wstrb  = strb;
        axi.wvalid = 1'b1;
        done = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            hs = axi.wready;
            @(posedge clk);
            #1;
            if (hs) done = 1;
        end
        axi.wvalid = 1'b0;
        if (!done) fail_timeout("w_handshake");
    endtask

    task automatic write_req(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        fork
            aw_only(addr);
            w_only(data, strb);
        join
    endtask

    task automatic write_resp(input string name);
        logic       hs;
        logic [1:0] resp;
        bit         done;
        axi.bready = 1'b1;
        done = 0;
        resp = 2'bxx;
        for (int n = 0; n < 50 && !done; n++) begin
            hs   = axi.bvalid;
            resp = axi.bresp;
            @(posedge clk);
            #1;
            if (hs) done = 1;
        end
        axi.bready = 1'b0;
        if (done) check({name, "_bresp"}, 32'(resp), 32'h0);
        else fail_timeout({name, "_b"});
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input string name);
        write_req(addr, data, strb);
        write_resp(name);
    endtask

    task automatic read_req(input logic [3:0] addr);
        logic hs;
        bit   done;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        done = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            hs = axi.arready;
            @(posedge clk);
            #1;
            if (hs) done = 1;
        end
        axi.arvalid = 1'b0;
        if (!done) fail_timeout("ar_handshake");
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
        logic        hs;
        logic [31:0] d;
        logic [1:0]  resp;
        bit          done;
        read_req(addr);
        axi.rready = 1'b1;
        done = 0;
        d    = 'x;
        resp = 2'bxx;
        for (int n = 0; n < 50 && !done; n++) begin
            hs   = axi.rvalid;
            d    = axi.rdata;
            resp = axi.rresp;
            @(posedge clk);
            #1;
            if (hs) done = 1;
        end
        axi.rready = 1'b0;
        if (done) begin
            check(name, d, exp);
            check({name, "_rresp"}, 32'(resp), 32'h0);
        end else begin
            fail_timeout({name, "_r"});
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        tag_byte     = b;
        tag_byte_vld = 1'b1;
        @(posedge clk);
        #1;
        tag_byte_vld = 1'b0;
    endtask

    int b_seen;

    initial begin
        vecs[0]  = '{1'b1, 4'h0, 32'h0000_0001, 4'hF, 32'h0};
        vecs[1]  = '{1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h0};
        vecs[2]  = '{1'b1, 4'h8, 32'h0000_0003, 4'hF, 32'h0};
        vecs[3]  = '{1'b1, 4'hC, 32'h0000_0004, 4'hF, 32'h0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0, 4'h0, 32'h0000_0001};
        vecs[5]  = '{1'b0, 4'h4, 32'h0, 4'h0, 32'h0000_0002};
        vecs[6]  = '{1'b0, 4'h8, 32'h0, 4'h0, 32'h0000_0000};
        vecs[7]  = '{1'b0, 4'hC, 32'h0, 4'h0, 32'h0000_0000};
        vecs[8]  = '{1'b1, 4'h4, 32'h0000_0000, 4'hF, 32'h0};
        vecs[9]  = '{1'b1, 4'h4, 32'hDEAD_BEEF, 4'b0101, 32'h0};
        vecs[10] = '{1'b0, 4'h4, 32'h0, 4'h0, 32'h00AD_00EF};
        vecs[11] = '{1'b1, 4'h0, 32'h0000_A5F3, 4'b0011, 32'h0};
        vecs[12] = '{1'b0, 4'h0, 32'h0, 4'h0, 32'h0000_A5F1};
        vecs[13] = '{1'b1, 4'h0, 32'h0000_0001, 4'hF, 32'h0};
        vecs[14] = '{1'b0, 4'h0, 32'h0, 4'h0, 32'h0000_0001};

        rst_n        = 1'b0;
        tag_byte     = 8'h00;
        tag_byte_vld = 1'b0;
        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata  = '0; axi.wstrb  = '0; axi.wvalid  = 1'b0;
        axi.bready = 1'b0;
        axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;

        #2;
        check("rst_awready", 32'(axi.awready), 32'h0);
        check("rst_wready",  32'(axi.wready),  32'h0);
        check("rst_arready", 32'(axi.arready), 32'h0);
        check("rst_bvalid",  32'(axi.bvalid),  32'h0);
        check("rst_rvalid",  32'(axi.rvalid),  32'h0);
        check("rst_rdata",   axi.rdata,        32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        check("post_rst_awready", 32'(axi.awready), 32'h1);

        // Register map table.
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_wr)
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, $sformatf("vec%0d", i));
            else
                axi_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // W arrives 3 cycles ahead of AW: exactly one write and one response.
        w_only(32'h1122_3344, 4'hF);
        idle(3);
        check("wfirst_no_b_yet", 32'(axi.bvalid), 32'h0);
        aw_only(4'h4);
        write_resp("wfirst");
        axi.bready = 1'b1;
        b_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (axi.bvalid) b_seen++;
            idle(1);
        end
        axi.bready = 1'b0;
        check("wfirst_extra_b", 32'(b_seen), 32'h0);
        axi_read(4'h4, 32'h1122_3344, "wfirst_scratch");

        // RREADY held low: RVALID/RDATA stable, ARREADY low.
        read_req(4'h4);
        for (int i = 0; i < 5; i++) begin
            check("rstall_rvalid",  32'(axi.rvalid),  32'h1);
            check("rstall_rdata",   axi.rdata,        32'h1122_3344);
            check("rstall_arready", 32'(axi.arready), 32'h0);
            idle(1);
        end
        axi.rready = 1'b1;
        idle(1);
        axi.rready = 1'b0;
        check("rstall_release", 32'(axi.rvalid), 32'h0);

        // BREADY held low: a second queued write must wait for the first response.
        write_req(4'h4, 32'hAAAA_0001, 4'hF);
        idle(2);
        check("bstall_bvalid", 32'(axi.bvalid), 32'h1);
        write_req(4'h4, 32'hBBBB_0002, 4'hF);
        idle(5);
        check("bstall_bvalid_hold", 32'(axi.bvalid), 32'h1);
        axi_read(4'h4, 32'hAAAA_0001, "bstall_not_applied");
        write_resp("bstall_b1");
        write_resp("bstall_b2");
        axi_read(4'h4, 32'hBBBB_0002, "bstall_applied");

        // Tag assembly and overrun (CTRL=1 from the table).
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        axi_read(4'hC, 32'h1234_5678, "tag1");
        axi_read(4'h8, 32'h0000_0001, "tag1_status");
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
        axi_read(4'hC, 32'h9ABC_DEF0, "tag2");
        axi_read(4'h8, 32'h0000_0003, "tag2_overrun");
        axi_write(4'h8, 32'h0000_0003, 4'hF, "w1c_flags");
        axi_read(4'h8, 32'h0000_0000, "w1c_status");

        // Each strobe restarts the gap timer: total span exceeds TMO but no gap does.
        send_byte(8'h01); send_byte(8'h02);
        idle(TMO - 4);
        send_byte(8'h03);
        idle(TMO - 4);
        send_byte(8'h04);
        axi_read(4'hC, 32'h0102_0304, "gap_tag");
        axi_read(4'h8, 32'h0000_0001, "gap_status");
        axi_write(4'h8, 32'h0000_0001, 4'hF, "gap_clr");

        // Gap timeout aborts a partial frame.
        send_byte(8'h05); send_byte(8'h06);
        axi_read(4'h8, 32'h0000_0020, "partial_cnt");
        idle(2 * TMO);
        axi_read(4'h8, 32'h0000_0004, "timeout_status");
        axi_write(4'h8, 32'h0000_0004, 4'hF, "ferr_clr");
        axi_read(4'h8, 32'h0000_0000, "ferr_cleared");
        axi_read(4'hC, 32'h0102_0304, "timeout_tag_kept");

        // Flush drops a partial frame; CTRL flush bit reads back 0.
        send_byte(8'h01); send_byte(8'h02);
        axi_write(4'h0, 32'h0000_0003, 4'hF, "flush");
        axi_read(4'h8, 32'h0000_0000, "flush_status");
        axi_read(4'h0, 32'h0000_0001, "flush_ctrl");
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        axi_read(4'hC, 32'hAABB_CCDD, "post_flush_tag");
        axi_write(4'h8, 32'h0000_0001, 4'hF, "post_flush_clr");

        // rx_en 1->0 drops the partial frame; bytes are ignored while disabled.
        send_byte(8'h11);
        axi_write(4'h0, 32'h0000_0000, 4'hF, "rx_off");
        axi_read(4'h8, 32'h0000_0000, "rx_off_status");
        send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'h24);
        axi_read(4'h8, 32'h0000_0000, "rx_off_dropped");
        axi_read(4'hC, 32'hAABB_CCDD, "rx_off_tag");
        axi_write(4'h0, 32'h0000_0001, 4'hF, "rx_on");

`ifdef RFID_REGS_IRQ_EN
        axi_write(4'h0, 32'h0000_0005, 4'hF, "irq_en");
        check("irq_idle", 32'(irq), 32'h0);
        send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
        send_byte(8'h34);
        check("irq_same_cycle", 32'(irq), 32'h0);
        idle(1);
        check("irq_next_cycle", 32'(irq), 32'h1);
        axi_write(4'h8, 32'h0000_0001, 4'hF, "irq_w1c");
        idle(2);
        check("irq_cleared", 32'(irq), 32'h0);
`endif

        // Asynchronous reset with a read and a write response outstanding.
        read_req(4'h4);
        write_req(4'h4, 32'hCAFE_0003, 4'hF);
        idle(1);
        aw_only(4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_awready", 32'(axi.awready), 32'h0);
        check("arst_wready",  32'(axi.wready),  32'h0);
        check("arst_arready", 32'(axi.arready), 32'h0);
        check("arst_bvalid",  32'(axi.bvalid),  32'h0);
        check("arst_rvalid",  32'(axi.rvalid),  32'h0);
        check("arst_rdata",   axi.rdata,        32'h0);
`ifdef RFID_REGS_IRQ_EN
        check("arst_irq", 32'(irq), 32'h0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        axi_read(4'h0, 32'h0, "arst_ctrl");
        axi_read(4'h4, 32'h0, "arst_scratch");
        axi_read(4'h8, 32'h0, "arst_status");
        axi_read(4'hC, 32'h0, "arst_tag");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
